// File: rtl/tag_cache_pkg.sv
// Shared constants, FSM state encoding and tag-word byte mapping for the tag cache bridge.
package tag_cache_pkg;

    // TileLink built-in acquire types
    localparam logic [2:0] A_GET       = 3'd0;
    localparam logic [2:0] A_GETBLOCK  = 3'd1;
    localparam logic [2:0] A_PUT       = 3'd2;
    localparam logic [2:0] A_PUTBLOCK  = 3'd3;

    // TileLink built-in grant types
    localparam logic [3:0] G_PUTACK       = 4'd1;
    localparam logic [3:0] G_GETDATABEAT  = 4'd3;
    localparam logic [3:0] G_GETDATABLOCK = 4'd4;

    // NASTI attributes: 8-byte beats, incrementing bursts, normal non-cacheable bufferable
    localparam logic [2:0] NASTI_SIZE_8B    = 3'd3;
    localparam logic [1:0] NASTI_BURST_INCR = 2'd1;
    localparam logic [3:0] NASTI_CACHE      = 4'b0011;
    localparam logic [7:0] NASTI_LEN_BLOCK  = 8'd7;
    localparam logic [7:0] NASTI_LEN_SINGLE = 8'd0;

    // One transaction at a time; reads fetch the tag word first, writes store it last.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_TAG_AR = 4'd1,
        ST_TAG_R  = 4'd2,
        ST_DAT_AR = 4'd3,
        ST_DAT_R  = 4'd4,
        ST_AW     = 4'd5,
        ST_WR_W   = 4'd6,
        ST_B      = 4'd7,
        ST_TAG_AW = 4'd8,
        ST_TAG_W  = 4'd9,
        ST_TAG_B  = 4'd10,
        ST_ACK    = 4'd11
    } state_e;

    // Byte i of the tag word holds the tag of beat i.
    function automatic logic [5:0] tag_byte_lsb(input logic [2:0] beat);
        return {beat, 3'b000};
    endfunction

endpackage

// File: rtl/tag_cache_top_tag_word_pack.sv
// Inserts one beat tag into a 64-bit tag word (with strobe) and extracts the tag of a beat.
module tag_word_pack
    import tag_cache_pkg::*;
#(
    parameter int TLTW = 4
) (
    input  logic [63:0]     word_in,
    input  logic [7:0]      strb_in,
    input  logic [2:0]      beat,
    input  logic [TLTW-1:0] tag_in,
    output logic [63:0]     word_out,
    output logic [7:0]      strb_out,
    output logic [TLTW-1:0] tag_out
);

    // Replace byte[beat] with the zero-extended tag, mark it written, and read back byte[beat].
    always_comb begin
        word_out = word_in;
        word_out[tag_byte_lsb(beat) +: 8] = 8'(tag_in);
        strb_out = strb_in | (8'd1 << beat);
        tag_out  = word_in[tag_byte_lsb(beat) +: TLTW];
    end

endmodule

// File: rtl/tag_cache_top.sv
// Single-tracker bridge from a TileLink uncached client port to a 64-bit NASTI port,
// keeping per-beat tags in a tag partition of the same memory.
// Handshake rule on every channel: a transfer happens on a rising edge where valid and
// ready are both high; valid never waits for ready and is held until the transfer.
module tag_cache_top
    import tag_cache_pkg::*;
#(
    parameter int              TLAW     = 32,
    parameter int              TLTW     = 4,
    parameter int              TLCIS    = 7,
    parameter int              TLMIS    = 2,
    parameter int              IDW      = 8,
    parameter logic [TLAW-1:0] TAG_BASE = 32'h0F00_0000
) (
    input  logic              clk,
    input  logic              reset,
    // acquire
    output logic              io_in_acquire_ready,
    input  logic              io_in_acquire_valid,
    input  logic [TLAW-7:0]   io_in_acquire_bits_addr_block,
    input  logic [TLCIS-1:0]  io_in_acquire_bits_client_xact_id,
    input  logic [2:0]        io_in_acquire_bits_addr_beat,
    input  logic              io_in_acquire_bits_is_builtin_type,
    input  logic [2:0]        io_in_acquire_bits_a_type,
    input  logic [12:0]       io_in_acquire_bits_union,
    input  logic [63:0]       io_in_acquire_bits_data,
    input  logic [TLTW-1:0]   io_in_acquire_bits_tag,
    input  logic              io_in_acquire_bits_client_id,
    // grant
    input  logic              io_in_grant_ready,
    output logic              io_in_grant_valid,
    output logic [2:0]        io_in_grant_bits_addr_beat,
    output logic [TLCIS-1:0]  io_in_grant_bits_client_xact_id,
    output logic [TLMIS-1:0]  io_in_grant_bits_manager_xact_id,
    output logic              io_in_grant_bits_is_builtin_type,
    output logic [3:0]        io_in_grant_bits_g_type,
    output logic [63:0]       io_in_grant_bits_data,
    output logic [TLTW-1:0]   io_in_grant_bits_tag,
    output logic              io_in_grant_bits_client_id,
    // finish
    output logic              io_in_finish_ready,
    input  logic              io_in_finish_valid,
    input  logic [TLMIS-1:0]  io_in_finish_bits_manager_xact_id,
    // probe
    input  logic              io_in_probe_ready,
    output logic              io_in_probe_valid,
    output logic [TLAW-7:0]   io_in_probe_bits_addr_block,
    output logic              io_in_probe_bits_p_type,
    output logic              io_in_probe_bits_client_id,
    // release
    output logic              io_in_release_ready,
    input  logic              io_in_release_valid,
    input  logic [2:0]        io_in_release_bits_addr_beat,
    input  logic [TLAW-7:0]   io_in_release_bits_addr_block,
    input  logic [TLCIS-1:0]  io_in_release_bits_client_xact_id,
    input  logic              io_in_release_bits_voluntary,
    input  logic [1:0]        io_in_release_bits_r_type,
    input  logic [63:0]       io_in_release_bits_data,
    input  logic [TLTW-1:0]   io_in_release_bits_tag,
    input  logic              io_in_release_bits_client_id,
    // NASTI aw
    output logic              io_out_aw_valid,
    input  logic              io_out_aw_ready,
    output logic [IDW-1:0]    io_out_aw_bits_id,
    output logic [TLAW-1:0]   io_out_aw_bits_addr,
    output logic [7:0]        io_out_aw_bits_len,
    output logic [2:0]        io_out_aw_bits_size,
    output logic [1:0]        io_out_aw_bits_burst,
    output logic              io_out_aw_bits_lock,
    output logic [3:0]        io_out_aw_bits_cache,
    output logic [2:0]        io_out_aw_bits_prot,
    output logic [3:0]        io_out_aw_bits_qos,
    output logic [3:0]        io_out_aw_bits_region,
    output logic              io_out_aw_bits_user,
    // NASTI ar
    output logic              io_out_ar_valid,
    input  logic              io_out_ar_ready,
    output logic [IDW-1:0]    io_out_ar_bits_id,
    output logic [TLAW-1:0]   io_out_ar_bits_addr,
    output logic [7:0]        io_out_ar_bits_len,
    output logic [2:0]        io_out_ar_bits_size,
    output logic [1:0]        io_out_ar_bits_burst,
    output logic              io_out_ar_bits_lock,
    output logic [3:0]        io_out_ar_bits_cache,
    output logic [2:0]        io_out_ar_bits_prot,
    output logic [3:0]        io_out_ar_bits_qos,
    output logic [3:0]        io_out_ar_bits_region,
    output logic              io_out_ar_bits_user,
    // NASTI w
    output logic              io_out_w_valid,
    input  logic              io_out_w_ready,
    output logic [63:0]       io_out_w_bits_data,
    output logic [7:0]        io_out_w_bits_strb,
    output logic              io_out_w_bits_last,
    output logic              io_out_w_bits_user,
    output logic [IDW-1:0]    io_out_w_bits_id,
    // NASTI b
    input  logic              io_out_b_valid,
    output logic              io_out_b_ready,
    input  logic [IDW-1:0]    io_out_b_bits_id,
    input  logic [1:0]        io_out_b_bits_resp,
    input  logic              io_out_b_bits_user,
    // NASTI r
    input  logic              io_out_r_valid,
    output logic              io_out_r_ready,
    input  logic [IDW-1:0]    io_out_r_bits_id,
    input  logic [63:0]       io_out_r_bits_data,
    input  logic [1:0]        io_out_r_bits_resp,
    input  logic              io_out_r_bits_last,
    input  logic              io_out_r_bits_user,
    input  logic              io_getpfc
);

    state_e            state_q, state_d;
    logic [TLAW-7:0]   addr_block_q, addr_block_d;
    logic [2:0]        beat_q, beat_d;
    logic [TLCIS-1:0]  xact_id_q, xact_id_d;
    logic              client_id_q, client_id_d;
    logic [2:0]        a_type_q, a_type_d;
    logic [63:0]       data_q, data_d;
    logic [7:0]        wmask_q, wmask_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [63:0]       tag_word_q, tag_word_d;
    logic [7:0]        tag_strb_q, tag_strb_d;

    logic              is_block_q, acq_is_block, acq_is_put;
    logic [TLAW-1:0]   data_addr, tag_addr;
    logic [63:0]       pk_word, pk_word_out;
    logic [7:0]        pk_strb, pk_strb_out;
    logic [2:0]        pk_beat;
    logic [TLTW-1:0]   pk_tag_out;

    logic              acq_ready_c, grant_valid_c, aw_valid_c, ar_valid_c, w_valid_c;
    logic              b_ready_c, r_ready_c;
    logic [2:0]        grant_beat_c;
    logic [3:0]        g_type_c;
    logic [63:0]       grant_data_c, w_data_c;
    logic [TLTW-1:0]   grant_tag_c;
    logic [TLAW-1:0]   nasti_addr_c;
    logic [7:0]        nasti_len_c, w_strb_c;
    logic              w_last_c;

    assign is_block_q   = (a_type_q == A_GETBLOCK) || (a_type_q == A_PUTBLOCK);
    assign acq_is_block = (io_in_acquire_bits_a_type == A_GETBLOCK) ||
                          (io_in_acquire_bits_a_type == A_PUTBLOCK);
    assign acq_is_put   = (io_in_acquire_bits_a_type == A_PUT) ||
                          (io_in_acquire_bits_a_type == A_PUTBLOCK);
    // Block transfers always start at beat 0; single-beat ones at the latched beat.
    assign data_addr    = {addr_block_q, (is_block_q ? 3'd0 : beat_q), 3'b000};
    assign tag_addr     = TAG_BASE + {3'b000, addr_block_q, 3'b000};

    // Select which tag-word slot is packed or read: fresh word on accept, running beat otherwise.
    always_comb begin
        pk_word = tag_word_q;
        pk_strb = tag_strb_q;
        pk_beat = cnt_q;
        if (state_q == ST_IDLE) begin
            pk_word = 64'd0;
            pk_strb = 8'd0;
            pk_beat = acq_is_block ? 3'd0 : io_in_acquire_bits_addr_beat;
        end else if (state_q == ST_DAT_R) begin
            pk_beat = is_block_q ? cnt_q : beat_q;
        end
    end

    tag_word_pack #(.TLTW(TLTW)) u_pack (
        .word_in  (pk_word),
        .strb_in  (pk_strb),
        .beat     (pk_beat),
        .tag_in   (io_in_acquire_bits_tag),
        .word_out (pk_word_out),
        .strb_out (pk_strb_out),
        .tag_out  (pk_tag_out)
    );

    // Next-state and channel handshakes for the read and write sequences.
    always_comb begin
        state_d      = state_q;
        addr_block_d = addr_block_q;
        beat_d       = beat_q;
        xact_id_d    = xact_id_q;
        client_id_d  = client_id_q;
        a_type_d     = a_type_q;
        data_d       = data_q;
        wmask_d      = wmask_q;
        cnt_d        = cnt_q;
        tag_word_d   = tag_word_q;
        tag_strb_d   = tag_strb_q;

        acq_ready_c   = 1'b0;
        grant_valid_c = 1'b0;
        aw_valid_c    = 1'b0;
        ar_valid_c    = 1'b0;
        w_valid_c     = 1'b0;
        b_ready_c     = 1'b0;
        r_ready_c     = 1'b0;
        grant_beat_c  = 3'd0;
        g_type_c      = 4'd0;
        grant_data_c  = 64'd0;
        grant_tag_c   = '0;
        nasti_addr_c  = data_addr;
        nasti_len_c   = NASTI_LEN_SINGLE;
        w_data_c      = 64'd0;
        w_strb_c      = 8'd0;
        w_last_c      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                acq_ready_c = 1'b1;
                if (io_in_acquire_valid) begin
                    addr_block_d = io_in_acquire_bits_addr_block;
                    beat_d       = io_in_acquire_bits_addr_beat;
                    xact_id_d    = io_in_acquire_bits_client_xact_id;
                    client_id_d  = io_in_acquire_bits_client_id;
                    a_type_d     = io_in_acquire_bits_a_type;
                    if (acq_is_put) begin
                        data_d     = io_in_acquire_bits_data;
                        wmask_d    = acq_is_block ? 8'hFF : io_in_acquire_bits_union[8:1];
                        tag_word_d = pk_word_out;
                        tag_strb_d = pk_strb_out;
                        state_d    = ST_AW;
                    end else begin
                        state_d    = ST_TAG_AR;
                    end
                end
            end
            ST_TAG_AR: begin
                ar_valid_c   = 1'b1;
                nasti_addr_c = tag_addr;
                if (io_out_ar_ready) state_d = ST_TAG_R;
            end
            ST_TAG_R: begin
                r_ready_c = 1'b1;
                if (io_out_r_valid) begin
                    tag_word_d = io_out_r_bits_data;
                    state_d    = ST_DAT_AR;
                end
            end
            ST_DAT_AR: begin
                ar_valid_c  = 1'b1;
                nasti_len_c = is_block_q ? NASTI_LEN_BLOCK : NASTI_LEN_SINGLE;
                if (io_out_ar_ready) begin
                    cnt_d   = 3'd0;
                    state_d = ST_DAT_R;
                end
            end
            ST_DAT_R: begin
                // Read data passes straight through to the grant channel.
                grant_valid_c = io_out_r_valid;
                r_ready_c     = io_in_grant_ready;
                grant_beat_c  = is_block_q ? cnt_q : beat_q;
                g_type_c      = is_block_q ? G_GETDATABLOCK : G_GETDATABEAT;
                grant_data_c  = io_out_r_bits_data;
                grant_tag_c   = pk_tag_out;
                if (io_out_r_valid && io_in_grant_ready) begin
                    cnt_d = cnt_q + 3'd1;
                    if (io_out_r_bits_last) state_d = ST_IDLE;
                end
            end
            ST_AW: begin
                aw_valid_c  = 1'b1;
                nasti_len_c = is_block_q ? NASTI_LEN_BLOCK : NASTI_LEN_SINGLE;
                if (io_out_aw_ready) begin
                    cnt_d   = 3'd0;
                    state_d = ST_WR_W;
                end
            end
            ST_WR_W: begin
                w_strb_c = wmask_q;
                w_last_c = !is_block_q || (cnt_q == 3'd7);
                if (cnt_q == 3'd0) begin
                    w_valid_c = 1'b1;
                    w_data_c  = data_q;
                end else begin
                    w_valid_c   = io_in_acquire_valid;
                    acq_ready_c = io_out_w_ready;
                    w_data_c    = io_in_acquire_bits_data;
                end
                if (w_valid_c && io_out_w_ready) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q != 3'd0) begin
                        tag_word_d = pk_word_out;
                        tag_strb_d = pk_strb_out;
                    end
                    if (w_last_c) state_d = ST_B;
                end
            end
            ST_B: begin
                b_ready_c = 1'b1;
                if (io_out_b_valid) state_d = ST_TAG_AW;
            end
            ST_TAG_AW: begin
                aw_valid_c   = 1'b1;
                nasti_addr_c = tag_addr;
                if (io_out_aw_ready) state_d = ST_TAG_W;
            end
            ST_TAG_W: begin
                w_valid_c = 1'b1;
                w_data_c  = tag_word_q;
                w_strb_c  = tag_strb_q;
                w_last_c  = 1'b1;
                if (io_out_w_ready) state_d = ST_TAG_B;
            end
            ST_TAG_B: begin
                b_ready_c = 1'b1;
                if (io_out_b_valid) state_d = ST_ACK;
            end
            ST_ACK: begin
                grant_valid_c = 1'b1;
                g_type_c      = G_PUTACK;
                if (io_in_grant_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latch registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_block_q <= '0;
            beat_q       <= '0;
            xact_id_q    <= '0;
            client_id_q  <= 1'b0;
            a_type_q     <= '0;
            data_q       <= '0;
            wmask_q      <= '0;
            cnt_q        <= '0;
            tag_word_q   <= '0;
            tag_strb_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_block_q <= addr_block_d;
            beat_q       <= beat_d;
            xact_id_q    <= xact_id_d;
            client_id_q  <= client_id_d;
            a_type_q     <= a_type_d;
            data_q       <= data_d;
            wmask_q      <= wmask_d;
            cnt_q        <= cnt_d;
            tag_word_q   <= tag_word_d;
            tag_strb_q   <= tag_strb_d;
        end
    end

    // Handshake outputs are forced low while reset is held.
    assign io_in_acquire_ready = acq_ready_c & ~reset;
    assign io_in_grant_valid   = grant_valid_c & ~reset;
    assign io_out_aw_valid     = aw_valid_c & ~reset;
    assign io_out_ar_valid     = ar_valid_c & ~reset;
    assign io_out_w_valid      = w_valid_c & ~reset;
    assign io_out_b_ready      = b_ready_c & ~reset;
    assign io_out_r_ready      = r_ready_c & ~reset;

    assign io_in_grant_bits_addr_beat       = grant_beat_c;
    assign io_in_grant_bits_client_xact_id  = xact_id_q;
    assign io_in_grant_bits_manager_xact_id = '0;
    assign io_in_grant_bits_is_builtin_type = 1'b1;
    assign io_in_grant_bits_g_type          = g_type_c;
    assign io_in_grant_bits_data            = grant_data_c;
    assign io_in_grant_bits_tag             = grant_tag_c;
    assign io_in_grant_bits_client_id       = client_id_q;

    assign io_in_finish_ready          = 1'b1;
    assign io_in_probe_valid           = 1'b0;
    assign io_in_probe_bits_addr_block = '0;
    assign io_in_probe_bits_p_type     = 1'b0;
    assign io_in_probe_bits_client_id  = 1'b0;
    assign io_in_release_ready         = 1'b1;

    assign io_out_aw_bits_id     = '0;
    assign io_out_aw_bits_addr   = nasti_addr_c;
    assign io_out_aw_bits_len    = nasti_len_c;
    assign io_out_aw_bits_size   = NASTI_SIZE_8B;
    assign io_out_aw_bits_burst  = NASTI_BURST_INCR;
    assign io_out_aw_bits_lock   = 1'b0;
    assign io_out_aw_bits_cache  = NASTI_CACHE;
    assign io_out_aw_bits_prot   = '0;
    assign io_out_aw_bits_qos    = '0;
    assign io_out_aw_bits_region = '0;
    assign io_out_aw_bits_user   = 1'b0;

    assign io_out_ar_bits_id     = '0;
    assign io_out_ar_bits_addr   = nasti_addr_c;
    assign io_out_ar_bits_len    = nasti_len_c;
    assign io_out_ar_bits_size   = NASTI_SIZE_8B;
    assign io_out_ar_bits_burst  = NASTI_BURST_INCR;
    assign io_out_ar_bits_lock   = 1'b0;
    assign io_out_ar_bits_cache  = NASTI_CACHE;
    assign io_out_ar_bits_prot   = '0;
    assign io_out_ar_bits_qos    = '0;
    assign io_out_ar_bits_region = '0;
    assign io_out_ar_bits_user   = 1'b0;

    assign io_out_w_bits_data = w_data_c;
    assign io_out_w_bits_strb = w_strb_c;
    assign io_out_w_bits_last = w_last_c;
    assign io_out_w_bits_user = 1'b0;
    assign io_out_w_bits_id   = '0;

    // Inputs that carry no meaning for this bridge (releases, finishes, responses, perf).
    logic unused_inputs;
    assign unused_inputs = ^{io_in_acquire_bits_is_builtin_type, io_in_acquire_bits_union,
                             io_in_finish_valid, io_in_finish_bits_manager_xact_id,
                             io_in_probe_ready, io_in_release_valid,
                             io_in_release_bits_addr_beat, io_in_release_bits_addr_block,
                             io_in_release_bits_client_xact_id, io_in_release_bits_voluntary,
                             io_in_release_bits_r_type, io_in_release_bits_data,
                             io_in_release_bits_tag, io_in_release_bits_client_id,
                             io_out_b_bits_id, io_out_b_bits_resp, io_out_b_bits_user,
                             io_out_r_bits_id, io_out_r_bits_resp, io_out_r_bits_user,
                             io_getpfc};

endmodule

// File: tb/tb_tag_cache_top.sv
// Directed bench for tag_cache_top: NASTI memory responder, grant monitor, scenario tasks.
module tb_tag_cache_top;

    localparam int TLAW = 32;
    localparam int TLTW = 4;
    localparam int TLCIS = 7;
    localparam int TLMIS = 2;
    localparam int IDW = 8;

    logic clk, reset;
    logic acq_ready, acq_valid, acq_builtin, acq_client_id;
    logic [TLAW-7:0] acq_block;
    logic [TLCIS-1:0] acq_xid;
    logic [2:0] acq_beat, acq_type;
    logic [12:0] acq_union;
    logic [63:0] acq_data;
    logic [TLTW-1:0] acq_tag;
    logic g_ready, g_valid, g_builtin, g_client_id;
    logic [2:0] g_beat;
    logic [TLCIS-1:0] g_xid;
    logic [TLMIS-1:0] g_mxid;
    logic [3:0] g_type;
    logic [63:0] g_data;
    logic [TLTW-1:0] g_tag;
    logic fin_ready;
    logic pr_valid, pr_ptype, pr_cid;
    logic [TLAW-7:0] pr_block;
    logic rel_ready;
    logic aw_valid, aw_ready, aw_lock, aw_user, ar_valid, ar_ready, ar_lock, ar_user;
    logic [IDW-1:0] aw_id, ar_id, w_id;
    logic [TLAW-1:0] aw_addr, ar_addr;
    logic [7:0] aw_len, ar_len, w_strb;
    logic [2:0] aw_size, ar_size, aw_prot, ar_prot;
    logic [1:0] aw_burst, ar_burst;
    logic [3:0] aw_cache, ar_cache, aw_qos, ar_qos, aw_region, ar_region;
    logic w_valid, w_ready, w_last, w_user;
    logic [63:0] w_data;
    logic b_valid, b_ready, r_valid, r_ready, r_last;
    logic [63:0] r_data;

    int n_cmp, n_fail;

    logic [63:0] mem [logic [31:0]];
    logic [31:0] aw_addr_log[$], ar_addr_log[$];
    logic [7:0]  aw_len_log[$], ar_len_log[$], w_strb_log[$];
    logic [63:0] w_data_log[$];
    logic        w_last_log[$];
    logic [2:0]  g_beat_log[$];
    logic [63:0] g_data_log[$];
    logic [3:0]  g_tag_log[$], g_type_log[$];
    logic [6:0]  g_xid_log[$];
    logic [63:0] exp_q[$];

    logic [31:0] rd_addr_q[$];
    logic [7:0]  rd_len_q[$];
    int rd_beat, wr_beat, b_pend;
    logic [31:0] wr_addr;

    tag_cache_top dut (
        .clk(clk), .reset(reset),
        .io_in_acquire_ready(acq_ready), .io_in_acquire_valid(acq_valid),
        .io_in_acquire_bits_addr_block(acq_block), .io_in_acquire_bits_client_xact_id(acq_xid),
        .io_in_acquire_bits_addr_beat(acq_beat), .io_in_acquire_bits_is_builtin_type(acq_builtin),
        .io_in_acquire_bits_a_type(acq_type), .io_in_acquire_bits_union(acq_union),
        .io_in_acquire_bits_data(acq_data), .io_in_acquire_bits_tag(acq_tag),
        .io_in_acquire_bits_client_id(acq_client_id),
        .io_in_grant_ready(g_ready), .io_in_grant_valid(g_valid),
        .io_in_grant_bits_addr_beat(g_beat), .io_in_grant_bits_client_xact_id(g_xid),
        .io_in_grant_bits_manager_xact_id(g_mxid), .io_in_grant_bits_is_builtin_type(g_builtin),
        .io_in_grant_bits_g_type(g_type), .io_in_grant_bits_data(g_data),
        .io_in_grant_bits_tag(g_tag), .io_in_grant_bits_client_id(g_client_id),
        .io_in_finish_ready(fin_ready), .io_in_finish_valid(1'b0),
        .io_in_finish_bits_manager_xact_id(2'd0),
        .io_in_probe_ready(1'b1), .io_in_probe_valid(pr_valid),
        .io_in_probe_bits_addr_block(pr_block), .io_in_probe_bits_p_type(pr_ptype),
        .io_in_probe_bits_client_id(pr_cid),
        .io_in_release_ready(rel_ready), .io_in_release_valid(1'b0),
        .io_in_release_bits_addr_beat(3'd0), .io_in_release_bits_addr_block(26'd0),
        .io_in_release_bits_client_xact_id(7'd0), .io_in_release_bits_voluntary(1'b0),
        .io_in_release_bits_r_type(2'd0), .io_in_release_bits_data(64'd0),
        .io_in_release_bits_tag(4'd0), .io_in_release_bits_client_id(1'b0),
        .io_out_aw_valid(aw_valid), .io_out_aw_ready(aw_ready), .io_out_aw_bits_id(aw_id),
        .io_out_aw_bits_addr(aw_addr), .io_out_aw_bits_len(aw_len), .io_out_aw_bits_size(aw_size),
        .io_out_aw_bits_burst(aw_burst), .io_out_aw_bits_lock(aw_lock), .io_out_aw_bits_cache(aw_cache),
        .io_out_aw_bits_prot(aw_prot), .io_out_aw_bits_qos(aw_qos), .io_out_aw_bits_region(aw_region),
        .io_out_aw_bits_user(aw_user),
        .io_out_ar_valid(ar_valid), .io_out_ar_ready(ar_ready), .io_out_ar_bits_id(ar_id),
        .io_out_ar_bits_addr(ar_addr), .io_out_ar_bits_len(ar_len), .io_out_ar_bits_size(ar_size),
        .io_out_ar_bits_burst(ar_burst), .io_out_ar_bits_lock(ar_lock), .io_out_ar_bits_cache(ar_cache),
        .io_out_ar_bits_prot(ar_prot), .io_out_ar_bits_qos(ar_qos), .io_out_ar_bits_region(ar_region),
        .io_out_ar_bits_user(ar_user),
        .io_out_w_valid(w_valid), .io_out_w_ready(w_ready), .io_out_w_bits_data(w_data),
        .io_out_w_bits_strb(w_strb), .io_out_w_bits_last(w_last), .io_out_w_bits_user(w_user),
        .io_out_w_bits_id(w_id),
        .io_out_b_valid(b_valid), .io_out_b_ready(b_ready), .io_out_b_bits_id(8'd0),
        .io_out_b_bits_resp(2'd0), .io_out_b_bits_user(1'b0),
        .io_out_r_valid(r_valid), .io_out_r_ready(r_ready), .io_out_r_bits_id(8'd0),
        .io_out_r_bits_data(r_data), .io_out_r_bits_resp(2'd0), .io_out_r_bits_last(r_last),
        .io_out_r_bits_user(1'b0),
        .io_getpfc(1'b0)
    );

    // Clock: rising edges at 5, 15, ...; inputs change on falling edges, sampling 1 ns before rising.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 64'd0;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] strb);
        logic [63:0] res;
        res = old;
        for (int k = 0; k < 8; k++) if (strb[k]) res[k*8 +: 8] = nw[k*8 +: 8];
        return res;
    endfunction

    // NASTI memory responder: always-ready address/data channels, in-order read data and b.
    initial begin
        aw_ready = 1'b1; ar_ready = 1'b1; w_ready = 1'b1;
        r_valid = 1'b0; r_last = 1'b0; r_data = 64'd0; b_valid = 1'b0;
        rd_beat = 0; wr_beat = 0; b_pend = 0; wr_addr = 32'd0;
        forever begin
            @(negedge clk);
            if (rd_addr_q.size() > 0) begin
                r_valid = 1'b1;
                r_data  = mem_rd(rd_addr_q[0] + 32'(rd_beat * 8));
                r_last  = (rd_beat == int'(rd_len_q[0]));
            end else begin
                r_valid = 1'b0; r_last = 1'b0; r_data = 64'd0;
            end
            b_valid = (b_pend > 0);
            #4;
            if (reset) begin
                rd_addr_q.delete(); rd_len_q.delete();
                rd_beat = 0; wr_beat = 0; b_pend = 0;
            end else begin
                if (ar_valid && ar_ready) begin
                    rd_addr_q.push_back(ar_addr); rd_len_q.push_back(ar_len);
                    ar_addr_log.push_back(ar_addr); ar_len_log.push_back(ar_len);
                end
                if (r_valid && r_ready) begin
                    if (r_last) begin
                        void'(rd_addr_q.pop_front()); void'(rd_len_q.pop_front()); rd_beat = 0;
                    end else rd_beat++;
                end
                if (aw_valid && aw_ready) begin
                    aw_addr_log.push_back(aw_addr); aw_len_log.push_back(aw_len);
                    wr_addr = aw_addr; wr_beat = 0;
                end
                if (w_valid && w_ready) begin
                    w_data_log.push_back(w_data); w_strb_log.push_back(w_strb);
                    w_last_log.push_back(w_last);
                    mem[wr_addr + 32'(wr_beat * 8)] =
                        merge(mem_rd(wr_addr + 32'(wr_beat * 8)), w_data, w_strb);
                    wr_beat++;
                    if (w_last) b_pend++;
                end
                if (b_valid && b_ready) b_pend--;
            end
        end
    end

    // Grant monitor: records every grant transfer.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!reset && g_valid && g_ready) begin
                g_beat_log.push_back(g_beat); g_data_log.push_back(g_data);
                g_tag_log.push_back(g_tag); g_type_log.push_back(g_type);
                g_xid_log.push_back(g_xid);
            end
        end
    end

    task automatic clear_logs();
        aw_addr_log.delete(); aw_len_log.delete(); ar_addr_log.delete(); ar_len_log.delete();
        w_data_log.delete(); w_strb_log.delete(); w_last_log.delete();
        g_beat_log.delete(); g_data_log.delete(); g_tag_log.delete();
        g_type_log.delete(); g_xid_log.delete();
    endtask

    // Present one acquire beat until accepted; called just after a falling edge.
    task automatic drive_acq(input logic [25:0] blk, input logic [2:0] beat, input logic [6:0] xid,
                             input logic [2:0] at, input logic [12:0] un, input logic [63:0] d,
                             input logic [3:0] tg);
        bit ok;
        ok = 1'b0;
        acq_block = blk; acq_beat = beat; acq_xid = xid; acq_type = at;
        acq_union = un; acq_data = d; acq_tag = tg; acq_valid = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            #4;
            if (acq_ready) ok = 1'b1;
            @(negedge clk);
        end
        acq_valid = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL acquire_accept: beat %0d type %0d never accepted (required accept within 100 cycles)", beat, at);
        end
    endtask

    task automatic wait_grants(input int n);
        for (int t = 0; t < 300 && g_beat_log.size() < n; t++) @(negedge clk);
        n_cmp++;
        if (g_beat_log.size() != n) begin
            n_fail++;
            $display("FAIL grant_count: got %0d grants, required %0d", g_beat_log.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #4;
            n_cmp++;
            if ({aw_valid, ar_valid, w_valid, g_valid, pr_valid} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_valids: cycle %0d valids %b, required 00000", c,
                         {aw_valid, ar_valid, w_valid, g_valid, pr_valid});
            end
        end
        @(negedge clk);
        reset = 1'b0;
        #4;
        n_cmp++;
        if (acq_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_acq_ready: got %b, required 1", acq_ready);
        end
        n_cmp++;
        if ({fin_ready, rel_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL const_readies: finish/release ready %b, required 11", {fin_ready, rel_ready});
        end
        @(negedge clk);
    endtask

    task automatic test_putblock();
        clear_logs();
        for (int i = 0; i < 8; i++)
            drive_acq(26'h10, 3'(i), 7'h15, 3'd3, 13'd0, 64'h100 + 64'(i), 4'(i));
        wait_grants(1);
        n_cmp++;
        if (aw_addr_log.size() != 2 || aw_addr_log[0] !== 32'h400 || aw_len_log[0] !== 8'd7 ||
            aw_addr_log[1] !== 32'h0F00_0080 || aw_len_log[1] !== 8'd0) begin
            n_fail++;
            $display("FAIL putblock_aw: %0d aw, addr0 %h len0 %0d (required 400/7, 0f000080/0)",
                     aw_addr_log.size(), aw_addr_log.size() > 0 ? aw_addr_log[0] : 32'hx,
                     aw_len_log.size() > 0 ? aw_len_log[0] : 8'hx);
        end
        n_cmp++;
        if (w_data_log.size() != 9) begin
            n_fail++;
            $display("FAIL putblock_w_count: got %0d w beats, required 9", w_data_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (w_data_log[i] !== 64'h100 + 64'(i) || w_strb_log[i] !== 8'hFF ||
                    w_last_log[i] !== (i == 7)) begin
                    n_fail++;
                    $display("FAIL putblock_w%0d: data %h strb %h last %b, required %h ff %b",
                             i, w_data_log[i], w_strb_log[i], w_last_log[i], 64'h100 + 64'(i), i == 7);
                end
            end
            n_cmp++;
            if (w_data_log[8] !== 64'h0706_0504_0302_0100 || w_strb_log[8] !== 8'hFF || w_last_log[8] !== 1'b1) begin
                n_fail++;
                $display("FAIL putblock_tag_w: data %h strb %h, required 0706050403020100 ff",
                         w_data_log[8], w_strb_log[8]);
            end
        end
        if (g_type_log.size() == 1) begin
            n_cmp++;
            if (g_type_log[0] !== 4'd1 || g_beat_log[0] !== 3'd0 || g_xid_log[0] !== 7'h15) begin
                n_fail++;
                $display("FAIL putblock_ack: type %0d beat %0d xid %h, required 1 0 15",
                         g_type_log[0], g_beat_log[0], g_xid_log[0]);
            end
        end
    endtask

    task automatic test_getblock(input logic [6:0] xid);
        clear_logs();
        for (int i = 0; i < 8; i++) exp_q.push_back(64'h100 + 64'(i));
        drive_acq(26'h10, 3'd0, xid, 3'd1, 13'd0, 64'd0, 4'd0);
        wait_grants(8);
        n_cmp++;
        if (ar_addr_log.size() != 2 || ar_addr_log[0] !== 32'h0F00_0080 || ar_len_log[0] !== 8'd0 ||
            ar_addr_log[1] !== 32'h400 || ar_len_log[1] !== 8'd7) begin
            n_fail++;
            $display("FAIL getblock_ar: %0d ar issued, required tag 0f000080/0 then 400/7", ar_addr_log.size());
        end
        for (int i = 0; i < 8; i++) begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if (i < g_beat_log.size()) begin
                n_cmp++;
                if (g_data_log[i] !== e || g_beat_log[i] !== 3'(i) || g_tag_log[i] !== 4'(i) ||
                    g_type_log[i] !== 4'd4 || g_xid_log[i] !== xid) begin
                    n_fail++;
                    $display("FAIL getblock_g%0d: data %h beat %0d tag %h type %0d xid %h, required %h %0d %h 4 %h",
                             i, g_data_log[i], g_beat_log[i], g_tag_log[i], g_type_log[i], g_xid_log[i],
                             e, i, i, xid);
                end
            end
        end
    endtask

    task automatic test_put_get();
        clear_logs();
        drive_acq(26'h20, 3'd5, 7'h03, 3'd2, 13'h01E, 64'h1122_3344_5566_7788, 4'hA);
        wait_grants(1);
        n_cmp++;
        if (aw_addr_log.size() != 2 || aw_addr_log[0] !== 32'h828 || aw_len_log[0] !== 8'd0 ||
            aw_addr_log[1] !== 32'h0F00_0100) begin
            n_fail++;
            $display("FAIL put_aw: %0d aw issued, required 828/0 then 0f000100", aw_addr_log.size());
        end
        if (w_data_log.size() == 2) begin
            n_cmp++;
            if (w_data_log[0] !== 64'h1122_3344_5566_7788 || w_strb_log[0] !== 8'h0F || w_last_log[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL put_w: data %h strb %h, required 1122334455667788 0f", w_data_log[0], w_strb_log[0]);
            end
            n_cmp++;
            if (w_data_log[1] !== 64'h0000_0A00_0000_0000 || w_strb_log[1] !== 8'h20) begin
                n_fail++;
                $display("FAIL put_tag_w: data %h strb %h, required 00000a0000000000 20", w_data_log[1], w_strb_log[1]);
            end
        end else begin
            n_cmp++; n_fail++;
            $display("FAIL put_w_count: got %0d w beats, required 2", w_data_log.size());
        end
        clear_logs();
        drive_acq(26'h20, 3'd5, 7'h04, 3'd0, 13'd0, 64'd0, 4'd0);
        wait_grants(1);
        if (g_beat_log.size() == 1) begin
            n_cmp++;
            if (g_tag_log[0] !== 4'hA || g_beat_log[0] !== 3'd5 || g_type_log[0] !== 4'd3 ||
                g_data_log[0] !== 64'h0000_0000_5566_7788 || g_xid_log[0] !== 7'h04) begin
                n_fail++;
                $display("FAIL get_beat: tag %h beat %0d type %0d data %h, required a 5 3 0000000055667788",
                         g_tag_log[0], g_beat_log[0], g_type_log[0], g_data_log[0]);
            end
        end
        n_cmp++;
        if (ar_addr_log.size() != 2 || ar_addr_log[1] !== 32'h828 || ar_len_log[1] !== 8'd0) begin
            n_fail++;
            $display("FAIL get_ar: %0d ar issued, required data read 828/0", ar_addr_log.size());
        end
    endtask

    task automatic test_grant_stall();
        int held;
        clear_logs();
        drive_acq(26'h10, 3'd0, 7'h11, 3'd1, 13'd0, 64'd0, 4'd0);
        for (int t = 0; t < 100 && g_beat_log.size() < 3; t++) @(negedge clk);
        g_ready = 1'b0;
        held = g_beat_log.size();
        for (int c = 0; c < 10; c++) begin
            #4;
            n_cmp++;
            if (r_ready !== 1'b0 || g_beat_log.size() != held) begin
                n_fail++;
                $display("FAIL stall_r_ready: cycle %0d r_ready %b grants %0d, required 0 and %0d",
                         c, r_ready, g_beat_log.size(), held);
            end
            @(negedge clk);
        end
        g_ready = 1'b1;
        wait_grants(8);
        for (int i = 0; i < 8 && i < g_beat_log.size(); i++) begin
            n_cmp++;
            if (g_data_log[i] !== 64'h100 + 64'(i) || g_beat_log[i] !== 3'(i) || g_tag_log[i] !== 4'(i)) begin
                n_fail++;
                $display("FAIL stall_order%0d: data %h beat %0d tag %h, required %h %0d %h",
                         i, g_data_log[i], g_beat_log[i], g_tag_log[i], 64'h100 + 64'(i), i, i);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        clear_logs();
        drive_acq(26'h30, 3'd0, 7'h22, 3'd3, 13'd0, 64'hDEAD, 4'd9);
        for (int c = 0; c < 4; c++) @(negedge clk);
        n_cmp++;
        if (w_data_log.size() != 1 || acq_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midwrite_setup: w beats %0d acq_ready %b, required 1 beat and ready 1",
                     w_data_log.size(), acq_ready);
        end
        reset = 1'b1;
        #4;
        n_cmp++;
        if ({aw_valid, ar_valid, w_valid, g_valid} !== 4'b0) begin
            n_fail++;
            $display("FAIL midwrite_reset_valids: %b, required 0000", {aw_valid, ar_valid, w_valid, g_valid});
        end
        @(negedge clk);
        reset = 1'b0;
        #4;
        n_cmp++;
        if (acq_ready !== 1'b1 || {aw_valid, ar_valid, w_valid, g_valid} !== 4'b0) begin
            n_fail++;
            $display("FAIL midwrite_idle: acq_ready %b valids %b, required 1 0000",
                     acq_ready, {aw_valid, ar_valid, w_valid, g_valid});
        end
        @(negedge clk);
        test_getblock(7'h33);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        reset = 1'b1;
        acq_valid = 1'b0; acq_block = '0; acq_xid = '0; acq_beat = '0; acq_builtin = 1'b1;
        acq_type = '0; acq_union = '0; acq_data = '0; acq_tag = '0; acq_client_id = 1'b0;
        g_ready = 1'b1;
        test_reset();
        test_putblock();
        test_getblock(7'h2A);
        test_put_get();
        test_grant_stall();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded 500000 ns");
        $fatal(1);
    end

endmodule
